// File: rtl/ej1_burst_arbiter_if.sv
// rtl/ej1_burst_arbiter_if.sv - requester, datapath and result signals of the ej1 burst arbiter
// master = stimulus/datapath side, slave = arbiter side.
interface ej1_burst_arbiter_if #(
  parameter int LEN_W = 4
);
  logic             req_a;
  logic [LEN_W-1:0] len_a;
  logic [1:0]       sym_a;
  logic             gnt_a;
  logic             req_b;
  logic [LEN_W-1:0] len_b;
  logic [1:0]       sym_b;
  logic             gnt_b;
  logic             dp_I;
  logic             dp_S;
  logic             dp_B1;
  logic             dp_B2;
  logic             res_valid;
  logic             res_owner;
  logic [1:0]       res_b;
  logic             busy;

  modport master (
    output req_a, len_a, sym_a, req_b, len_b, sym_b, dp_B1, dp_B2,
    input  gnt_a, gnt_b, dp_I, dp_S, res_valid, res_owner, res_b, busy
  );

  modport slave (
    input  req_a, len_a, sym_a, req_b, len_b, sym_b, dp_B1, dp_B2,
    output gnt_a, gnt_b, dp_I, dp_S, res_valid, res_owner, res_b, busy
  );
endinterface

// File: rtl/ej1_burst_arbiter.sv
// rtl/ej1_burst_arbiter.sv - round-robin burst arbiter sharing one ej1a datapath between A and B
// Bursts of LEN symbols, idle I=0 gap between bursts, owner-tagged results two cycles after grant.
module ej1_burst_arbiter #(
  parameter int LEN_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  ej1_burst_arbiter_if.slave  bus
);
  localparam int CNT_W = LEN_W + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_owner;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [GAP_W-1:0] r_gap;
  logic             r_dp_I;
  logic             r_dp_S;
  logic             r_v1;
  logic             r_o1;
  logic             r_v2;
  logic             r_o2;

  logic             w_any_req;
  logic             w_pick_b;
  logic [LEN_W-1:0] w_len;
  logic [CNT_W-1:0] w_len_ext;
  logic             w_last_sym;
  logic             w_gap_done;
  logic             w_gnt_a;
  logic             w_gnt_b;
  logic             w_gnt_any;
  logic             w_busy;
  logic [1:0]       w_sym;

  // On a tie, the requester not served last wins; r_last=1 means B was last.
  assign w_any_req  = bus.req_a | bus.req_b;
  assign w_pick_b   = bus.req_b & (~bus.req_a | ~r_last);
  assign w_len      = w_pick_b ? bus.len_b : bus.len_a;
  assign w_len_ext  = (w_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, w_len};
  assign w_last_sym = (r_cnt == CNT_W'(1));
  assign w_gap_done = (r_gap == GAP_W'(GAP_CYCLES - 1));
  assign w_sym      = r_owner ? bus.sym_b : bus.sym_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req)  w_next_state = S_RUN;
      S_RUN:   if (w_last_sym) w_next_state = S_GAP;
      S_GAP:   if (w_gap_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_gnt_a   = 1'b0;
    w_gnt_b   = 1'b0;
    w_busy    = 1'b0;
    if (r_state == S_RUN) begin
      w_gnt_a = ~r_owner;
      w_gnt_b = r_owner;
    end
    if (r_state != S_IDLE) begin
      w_busy = 1'b1;
    end
  end

  assign w_gnt_any = w_gnt_a | w_gnt_b;

  // Any non-grant edge loads I=0,S=0, which drives ej1a back to B1=B2=1 before the next burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_dp_I  <= 1'b0;
      r_dp_S  <= 1'b0;
      r_v1    <= 1'b0;
      r_o1    <= 1'b0;
      r_v2    <= 1'b0;
      r_o2    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_pick_b;
            r_cnt   <= w_len_ext;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last_sym) begin
            r_last <= r_owner;
            r_gap  <= '0;
          end
        end
        S_GAP: begin
          r_gap <= r_gap + GAP_W'(1);
        end
        default: ;
      endcase
      r_dp_I <= w_gnt_any & w_sym[0];
      r_dp_S <= w_gnt_any & w_sym[1];
      r_v1   <= w_gnt_any;
      r_o1   <= r_owner;
      r_v2   <= r_v1;
      r_o2   <= r_o1;
    end
  end

  assign bus.gnt_a     = w_gnt_a;
  assign bus.gnt_b     = w_gnt_b;
  assign bus.busy      = w_busy;
  assign bus.dp_I      = r_dp_I;
  assign bus.dp_S      = r_dp_S;
  assign bus.res_valid = r_v2;
  assign bus.res_owner = r_o2;
  assign bus.res_b     = {bus.dp_B2, bus.dp_B1};
endmodule
